// File: rtl/wor_bus_arbiter_pkg.sv
// wor_arb_pkg: shared types and constants for the wired-OR bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wor_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  // Idle cycles inserted between two owners
  localparam int TURN_CYCLES = 1;

  // Ceiling log2, never less than 1 so it can size a vector
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/wor_bus_arbiter_if.sv
// wor_bus_arbiter_if: request/grant/data bundle between requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; optional WOR_CONTENTION_CHECK_EN adds bus_in and contention.
interface wor_bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    done;
  logic [N_REQ*DW-1:0] wr_data;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ*DW-1:0] drv_data;
  logic                bus_busy;
  logic                timeout;
`ifdef WOR_CONTENTION_CHECK_EN
  logic [DW-1:0]       bus_in;
  logic                contention;

  modport master (
    input  req, done, wr_data, bus_in,
    output gnt, drv_data, bus_busy, timeout, contention
  );

  modport slave (
    output req, done, wr_data, bus_in,
    input  gnt, drv_data, bus_busy, timeout, contention
  );
`else
  modport master (
    input  req, done, wr_data,
    output gnt, drv_data, bus_busy, timeout
  );

  modport slave (
    output req, done, wr_data,
    input  gnt, drv_data, bus_busy, timeout
  );
`endif
endinterface

// File: rtl/wor_bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting at rr_ptr and wrapping at N_REQ-1.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [PW-1:0]    win_idx_o
);

  // Scan upward from rr_ptr and take the first asserted request
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr_i) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        win_oh_o[idx]  = 1'b1;
        win_idx_o      = idx;
      end
    end
  end

endmodule

// File: rtl/wor_bus_arbiter.sv
// wor_bus_arbiter: round-robin grant of N_REQ requesters onto a wired-OR bus, non-owner lanes forced to 0.
// Latency: grant 1 clk after request from idle; one all-zero turnaround cycle between owners.
// Backpressure: none; owner holds via level req, releases via done, req drop or HOLD_MAX timeout.
// Optional feature macro: WOR_CONTENTION_CHECK_EN (bus_in input, sticky contention output).
module wor_bus_arbiter
  import wor_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  wor_bus_arbiter_if.master bus
);

  localparam int            PW        = clog2(N_REQ);
  localparam int            HW        = clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  arb_state_t          state_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [PW-1:0]       owner_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [HW-1:0]       hold_cnt_q;
  logic                timeout_q;

  logic [N_REQ-1:0]    win_oh;
  logic [PW-1:0]       win_idx;
  logic                owner_release;
  logic [PW-1:0]       rr_ptr_d;
  logic [HW-1:0]       hold_cnt_d;
  logic [N_REQ*DW-1:0] drv_dat;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // Only the owner's done/req matter; the hold limit forces release on the last allowed cycle
  assign owner_release = bus.done[owner_q] | ~bus.req[owner_q] | (hold_cnt_q == HOLD_LAST);
  assign rr_ptr_d      = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
  assign hold_cnt_d    = hold_cnt_q + HW'(1);

  // Arbitration FSM; timeout is registered one cycle early so it lines up with the last BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE, TURN: begin
          // TURN always lasts TURN_CYCLES (one) cycle: gnt is already 0 here
          if (|bus.req) begin
            state_q    <= BUSY;
            gnt_q      <= win_oh;
            owner_q    <= win_idx;
            hold_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (owner_release) begin
            state_q    <= TURN;
            gnt_q      <= '0;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= (hold_cnt_d == HOLD_LAST);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Lane gating: non-owner lanes are zero so the wired-OR equals the owner's data
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign drv_dat[i*DW +: DW] = gnt_q[i] ? bus.wr_data[i*DW +: DW] : '0;
  end

  assign bus.drv_data = drv_dat;
  assign bus.gnt      = gnt_q;
  assign bus.bus_busy = |gnt_q;
  assign bus.timeout  = timeout_q;

`ifdef WOR_CONTENTION_CHECK_EN
  logic [DW-1:0] owner_lane;
  logic          contention_q;

  // OR of the gated lanes is the owner's data when busy and zero when idle
  always_comb begin
    owner_lane = '0;
    for (int i = 0; i < N_REQ; i++) owner_lane = owner_lane | drv_dat[i*DW +: DW];
  end

  // Sticky flag: resolved net differs from what we drive (covers rogue drivers while idle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) contention_q <= 1'b0;
    else if (bus.bus_in != owner_lane) contention_q <= 1'b1;
  end

  assign bus.contention = contention_q;
`endif

endmodule
